// File: rtl/vga_timing_monitor.sv
// Passive checker for a VGA sync/pixel stream: measures line and frame geometry,
// flags timing errors per frame and accumulates a checksum of the active window.
module vga_timing_monitor #(
    parameter int H_SYNC      = 96,
    parameter int H_TOTAL     = 800,
    parameter int H_ACT_START = 144,
    parameter int H_ACT       = 640,
    parameter int V_SYNC      = 2,
    parameter int V_TOTAL     = 525,
    parameter int V_ACT_START = 35,
    parameter int V_ACT       = 480
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        pix_en,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [15:0] rgb,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [3:0]  err_flags,
    output logic [23:0] checksum,
    output logic [15:0] frame_cnt,
    output logic [7:0]  err_cnt
);
    localparam logic [10:0] C_H_TOTAL = 11'(H_TOTAL);
    localparam logic [10:0] C_V_TOTAL = 11'(V_TOTAL);
    localparam logic [9:0]  C_H_SYNC  = 10'(H_SYNC);
    localparam logic [9:0]  C_V_SYNC  = 10'(V_SYNC);
    localparam logic [9:0]  C_H_FIRST = 10'(H_ACT_START);
    localparam logic [9:0]  C_H_LAST  = 10'(H_ACT_START + H_ACT - 1);
    localparam logic [9:0]  C_V_FIRST = 10'(V_ACT_START);
    localparam logic [9:0]  C_V_LAST  = 10'(V_ACT_START + V_ACT - 1);

    typedef enum logic {ST_WAIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_hs_prev;
    logic        r_vs_prev;
    logic [9:0]  r_h_cnt;
    logic [9:0]  r_hs_width;
    logic [9:0]  r_line;
    logic [9:0]  r_vs_lines;
    logic        r_line_valid;
    logic [1:0]  r_line_err;
    logic [23:0] r_acc;

    logic        r_frame_done;
    logic        r_frame_ok;
    logic [3:0]  r_err_flags;
    logic [23:0] r_checksum;
    logic [15:0] r_frame_cnt;
    logic [7:0]  r_err_cnt;

    logic        w_hs_rise;
    logic        w_vs_rise;
    logic        w_start;
    logic        w_close;
    logic        w_line_chk;
    logic [9:0]  w_h_cur;
    logic [9:0]  w_line_cur;
    logic        w_active;
    logic        w_len_err;
    logic        w_hsw_err;
    logic [3:0]  w_flags;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= ST_WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_WAIT && w_vs_rise) begin
            w_state_nxt = ST_RUN;
        end
    end

    always_comb begin
        w_start = (r_state == ST_WAIT) && w_vs_rise;
        w_close = (r_state == ST_RUN) && w_vs_rise;
    end

    // h/line values belong to the pixel being sampled now, not the previous one
    always_comb begin
        w_hs_rise  = pix_en & hsync & ~r_hs_prev;
        w_vs_rise  = pix_en & vsync & ~r_vs_prev;
        w_h_cur    = w_hs_rise ? 10'd0 : r_h_cnt + 10'd1;
        w_line_cur = w_vs_rise ? 10'd0 : (w_hs_rise ? r_line + 10'd1 : r_line);
        w_active   = (w_h_cur >= C_H_FIRST) && (w_h_cur <= C_H_LAST) &&
                     (w_line_cur >= C_V_FIRST) && (w_line_cur <= C_V_LAST);
        w_line_chk = (r_state == ST_RUN) && w_hs_rise && r_line_valid;
        w_len_err  = w_line_chk && (({1'b0, r_h_cnt} + 11'd1) != C_H_TOTAL);
        w_hsw_err  = w_line_chk && (r_hs_width != C_H_SYNC);
        // A coincident hsync rise closes the last line of the frame being latched
        w_flags    = {(r_vs_lines != C_V_SYNC),
                      (({1'b0, r_line} + 11'd1) != C_V_TOTAL),
                      r_line_err[1] | w_hsw_err,
                      r_line_err[0] | w_len_err};
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_hs_prev    <= 1'b0;
            r_vs_prev    <= 1'b0;
            r_h_cnt      <= 10'd0;
            r_hs_width   <= 10'd0;
            r_line       <= 10'd0;
            r_vs_lines   <= 10'd0;
            r_line_valid <= 1'b0;
            r_line_err   <= 2'b00;
            r_acc        <= 24'd0;
            r_frame_done <= 1'b0;
            r_frame_ok   <= 1'b0;
            r_err_flags  <= 4'd0;
            r_checksum   <= 24'd0;
            r_frame_cnt  <= 16'd0;
            r_err_cnt    <= 8'd0;
        end else begin
            r_frame_done <= 1'b0;
            if (pix_en) begin
                r_hs_prev <= hsync;
                r_vs_prev <= vsync;
                r_h_cnt   <= w_h_cur;
                if (w_hs_rise) begin
                    r_hs_width <= 10'd1;
                end else if (hsync && r_hs_width != 10'h3FF) begin
                    r_hs_width <= r_hs_width + 10'd1;
                end

                if (w_vs_rise) begin
                    r_line     <= 10'd0;
                    r_vs_lines <= w_hs_rise ? 10'd1 : 10'd0;
                    r_acc      <= w_active ? {8'd0, rgb} : 24'd0;
                    r_line_err <= 2'b00;
                end else if (r_state == ST_RUN) begin
                    if (w_hs_rise) begin
                        r_line <= r_line + 10'd1;
                        if (vsync) begin
                            r_vs_lines <= r_vs_lines + 10'd1;
                        end
                    end
                    if (w_active) begin
                        r_acc <= r_acc + {8'd0, rgb};
                    end
                    r_line_err <= r_line_err | {w_hsw_err, w_len_err};
                end

                // The line in progress when RUN begins has no trustworthy start
                if (w_start) begin
                    r_line_valid <= 1'b0;
                end else if (r_state == ST_RUN && w_hs_rise) begin
                    r_line_valid <= 1'b1;
                end

                if (w_close) begin
                    r_frame_done <= 1'b1;
                    r_err_flags  <= w_flags;
                    r_frame_ok   <= (w_flags == 4'd0);
                    r_checksum   <= r_acc;
                    r_frame_cnt  <= r_frame_cnt + 16'd1;
                    if (w_flags != 4'd0 && r_err_cnt != 8'hFF) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
                end
            end
        end
    end

    assign frame_done = r_frame_done;
    assign frame_ok   = r_frame_ok;
    assign err_flags  = r_err_flags;
    assign checksum   = r_checksum;
    assign frame_cnt  = r_frame_cnt;
    assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Bench for vga_timing_monitor: drives whole frames described as per-line lengths and
// sync widths, predicts each frame result from those descriptions and scores every cycle.
module tb_vga_timing_monitor;
    localparam int HS  = 3;
    localparam int HT  = 12;
    localparam int HAS = 4;
    localparam int HA  = 6;
    localparam int VS  = 2;
    localparam int VT  = 8;
    localparam int VAS = 3;
    localparam int VA  = 4;

    logic        clk    = 1'b0;
    logic        rst    = 1'b0;
    logic        pix_en = 1'b0;
    logic        hsync  = 1'b0;
    logic        vsync  = 1'b0;
    logic [15:0] rgb    = 16'd0;
    logic        frame_done;
    logic        frame_ok;
    logic [3:0]  err_flags;
    logic [23:0] checksum;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    vga_timing_monitor #(
        .H_SYNC(HS), .H_TOTAL(HT), .H_ACT_START(HAS), .H_ACT(HA),
        .V_SYNC(VS), .V_TOTAL(VT), .V_ACT_START(VAS), .V_ACT(VA)
    ) dut (
        .sys_clk(clk),
        .sys_rst(rst),
        .pix_en(pix_en),
        .hsync(hsync),
        .vsync(vsync),
        .rgb(rgb),
        .frame_done(frame_done),
        .frame_ok(frame_ok),
        .err_flags(err_flags),
        .checksum(checksum),
        .frame_cnt(frame_cnt),
        .err_cnt(err_cnt)
    );

    // {err_cnt, frame_cnt, err_flags, checksum, frame_ok}
    logic [52:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    int          line_len[0:15];
    int          line_hw[0:15];

    bit          m_synced     = 1'b0;
    bit          m_pend_valid = 1'b0;
    logic [3:0]  m_pend_flags = 4'd0;
    logic [23:0] m_pend_sum   = 24'd0;
    logic [15:0] m_frame_cnt  = 16'd0;
    logic [7:0]  m_err_cnt    = 8'd0;

    task automatic model_reset();
        m_synced     = 1'b0;
        m_pend_valid = 1'b0;
        m_frame_cnt  = 16'd0;
        m_err_cnt    = 8'd0;
        exp_q.delete();
    endtask

    task automatic model_close();
        m_frame_cnt = m_frame_cnt + 16'd1;
        if (m_pend_flags != 4'd0 && m_err_cnt != 8'd255) m_err_cnt = m_err_cnt + 8'd1;
        exp_q.push_back({m_err_cnt, m_frame_cnt, m_pend_flags, m_pend_sum, (m_pend_flags == 4'd0)});
    endtask

    // One clock: score what the previous edge produced, then present the next input set.
    task automatic tick(input logic pe, input logic hs, input logic vs, input logic [15:0] px);
        logic [52:0] e;
        @(negedge clk);
        n_checks++;
        if (frame_done) begin
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_frame_done at %0t: frame_done=1 required=0", $time);
            end else begin
                e = exp_q.pop_front();
                if ({err_cnt, frame_cnt, err_flags, checksum, frame_ok} !== e) begin
                    n_fail++;
                    $display("FAIL frame_result at %0t: got err_cnt=%0d frame_cnt=%0d flags=%b sum=%h ok=%b, required err_cnt=%0d frame_cnt=%0d flags=%b sum=%h ok=%b",
                             $time, err_cnt, frame_cnt, err_flags, checksum, frame_ok,
                             e[52:45], e[44:29], e[28:25], e[24:1], e[0]);
                end
            end
        end else if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_frame_done at %0t: frame_done=0 required=1", $time);
            exp_q.delete();
        end
        pix_en = pe;
        hsync  = hs;
        vsync  = vs;
        rgb    = px;
    endtask

    task automatic pulse_reset(input string tag);
        pix_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({frame_done, frame_ok, err_flags, checksum, frame_cnt, err_cnt} !== 54'd0) begin
            n_fail++;
            $display("FAIL %s_outputs_cleared: got done=%b ok=%b flags=%b sum=%h fcnt=%0d ecnt=%0d, required all zero",
                     tag, frame_done, frame_ok, err_flags, checksum, frame_cnt, err_cnt);
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_nominal();
        for (int i = 0; i < 16; i++) begin
            line_len[i] = HT;
            line_hw[i]  = HS;
        end
    endtask

    // Drives one frame starting with its vsync rise. mode 0: constant F800, 1: random rgb,
    // 2: random nonzero rgb outside the active window and zero inside.
    task automatic drive_frame(input int nl, input int vw, input int mode,
                               input int idle_min, input int idle_max, input int rst_line);
        logic [23:0] sum;
        logic [3:0]  fl;
        logic [15:0] px;
        bit          first;
        bit          act;
        sum   = 24'd0;
        fl    = 4'd0;
        first = 1'b0;
        for (int l = 0; l < nl; l++) begin
            for (int h = 0; h < line_len[l]; h++) begin
                act = (h >= HAS) && (h < HAS + HA) && (l >= VAS) && (l < VAS + VA);
                case (mode)
                    0:       px = 16'hF800;
                    1:       px = 16'($urandom);
                    default: px = act ? 16'd0 : 16'($urandom_range(1, 65535));
                endcase
                if (l == rst_line && h == line_hw[l] + 1) pulse_reset("mid_frame_reset");
                repeat ($urandom_range(idle_min, idle_max))
                    tick(1'b0, 1'($urandom), 1'($urandom), 16'($urandom));
                tick(1'b1, (h < line_hw[l]), (l < vw), px);
                if (act) sum = sum + 24'(px);
                if (l == 0 && h == 0) begin
                    if (m_pend_valid) model_close();
                    first    = !m_synced;
                    m_synced = 1'b1;
                end
            end
        end
        for (int l = 0; l < nl; l++) begin
            if (!(first && l == 0)) begin
                if (line_len[l] != HT) fl[0] = 1'b1;
                if (line_hw[l] != HS)  fl[1] = 1'b1;
            end
        end
        fl[2] = (nl != VT);
        fl[3] = (vw != VS);
        m_pend_valid = m_synced;
        m_pend_flags = fl;
        m_pend_sum   = sum;
    endtask

    task automatic test_reset();
        pulse_reset("power_on_reset");
        n_checks++;
        if (frame_cnt !== 16'd0 || err_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got fcnt=%0d ecnt=%0d, required 0 0", frame_cnt, err_cnt);
        end
    endtask

    task automatic test_nominal();
        set_nominal();
        drive_frame(VT, VS, 0, 1, 1, -1);
        n_checks++;
        if (frame_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL nominal_first_vsync: got fcnt=%0d required 0", frame_cnt);
        end
        drive_frame(VT, VS, 0, 1, 1, -1);
        n_checks++;
        if (checksum !== 24'(HA * VA * 32'hF800) || err_flags !== 4'd0 || frame_ok !== 1'b1 ||
            frame_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL nominal_frame: got sum=%h flags=%b ok=%b fcnt=%0d, required sum=%h flags=0000 ok=1 fcnt=1",
                     checksum, err_flags, frame_ok, frame_cnt, 24'(HA * VA * 32'hF800));
        end
        drive_frame(VT, VS, 0, 1, 1, -1);
        n_checks++;
        if (frame_cnt !== 16'd2 || checksum !== 24'(HA * VA * 32'hF800)) begin
            n_fail++;
            $display("FAIL nominal_second: got fcnt=%0d sum=%h, required fcnt=2 sum=%h",
                     frame_cnt, checksum, 24'(HA * VA * 32'hF800));
        end
    endtask

    task automatic test_line_length();
        pulse_reset("line_length_reset");
        set_nominal();
        line_len[4] = HT - 1;
        drive_frame(VT, VS, 1, 0, 2, -1);
        set_nominal();
        drive_frame(VT, VS, 1, 0, 2, -1);
        n_checks++;
        if (err_flags !== 4'b0001 || frame_ok !== 1'b0 || err_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL short_line: got flags=%b ok=%b ecnt=%0d, required 0001 0 1", err_flags, frame_ok, err_cnt);
        end
        drive_frame(VT, VS, 1, 0, 2, -1);
        n_checks++;
        if (err_flags !== 4'b0000 || frame_ok !== 1'b1 || err_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL recovered_line: got flags=%b ok=%b ecnt=%0d, required 0000 1 1", err_flags, frame_ok, err_cnt);
        end
    endtask

    task automatic test_sync_widths();
        pulse_reset("sync_width_reset");
        set_nominal();
        line_hw[5] = HS - 1;
        drive_frame(VT, VS + 1, 1, 0, 2, -1);
        set_nominal();
        drive_frame(VT, VS, 1, 0, 2, -1);
        n_checks++;
        if (err_flags !== 4'b1010 || frame_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL sync_widths: got flags=%b ok=%b, required 1010 0", err_flags, frame_ok);
        end
    endtask

    task automatic test_outside_active();
        pulse_reset("outside_reset");
        set_nominal();
        drive_frame(VT, VS, 2, 0, 1, -1);
        drive_frame(VT, VS, 2, 0, 1, -1);
        n_checks++;
        if (checksum !== 24'd0 || frame_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL outside_active: got sum=%h ok=%b, required 000000 1", checksum, frame_ok);
        end
    endtask

    task automatic test_mid_reset();
        set_nominal();
        drive_frame(VT, VS, 0, 0, 1, 4);
        drive_frame(VT, VS, 0, 0, 1, -1);
        n_checks++;
        if (frame_cnt !== 16'd0 || frame_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_first_vsync: got fcnt=%0d ok=%b, required 0 0", frame_cnt, frame_ok);
        end
        drive_frame(VT, VS, 0, 0, 1, -1);
        n_checks++;
        if (frame_cnt !== 16'd1 || frame_ok !== 1'b1 || checksum !== 24'(HA * VA * 32'hF800)) begin
            n_fail++;
            $display("FAIL post_reset_frame: got fcnt=%0d ok=%b sum=%h, required 1 1 %h",
                     frame_cnt, frame_ok, checksum, 24'(HA * VA * 32'hF800));
        end
    endtask

    task automatic test_random();
        int nl;
        int vw;
        pulse_reset("random_reset");
        for (int f = 0; f < 10; f++) begin
            set_nominal();
            nl = VT;
            vw = VS;
            if (f > 0 && $urandom_range(0, 1) == 1) begin
                nl = $urandom_range(VT - 1, VT + 1);
                vw = $urandom_range(1, VS + 1);
                line_len[$urandom_range(1, nl - 1)] = $urandom_range(HT - 1, HT + 1);
                line_hw[$urandom_range(1, nl - 1)]  = $urandom_range(HS - 1, HS + 1);
            end
            drive_frame(nl, vw, 1, 0, 3, -1);
        end
        n_checks++;
        if (frame_cnt !== 16'd9 || err_cnt !== m_err_cnt) begin
            n_fail++;
            $display("FAIL random_counts: got fcnt=%0d ecnt=%0d, required 9 %0d", frame_cnt, err_cnt, m_err_cnt);
        end
    endtask

    task automatic test_saturation();
        pulse_reset("saturation_reset");
        set_nominal();
        for (int f = 0; f <= 300; f++) begin
            drive_frame(VT - 1, VS, 0, 0, 0, -1);
            if (f > 0) begin
                n_checks++;
                if (err_flags !== 4'b0100) begin
                    n_fail++;
                    $display("FAIL short_frame_flags frame %0d: got %b required 0100", f, err_flags);
                end
            end
        end
        n_checks++;
        if (err_cnt !== 8'd255 || frame_cnt !== 16'd300) begin
            n_fail++;
            $display("FAIL saturation: got ecnt=%0d fcnt=%0d, required 255 300", err_cnt, frame_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_line_length();
        test_sync_widths();
        test_outside_active();
        test_mid_reset();
        test_random();
        test_saturation();
        tick(1'b0, 1'b0, 1'b0, 16'd0);
        tick(1'b0, 1'b0, 1'b0, 16'd0);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_results: got %0d outstanding required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
